// File: rtl/sram_responder_if.sv
// Address, strobe and status bundle shared by the SRAM bus master and sram_responder.
// The wr_count/rd_count debug counters exist only when SRAM_STATS_EN is defined.
interface sram_responder_if #(
  parameter int AW = 3
);
  logic [AW-1:0] addr;
  logic          wr_enable;
  logic          rd_enable;
  logic [1:0]    phase;
  logic          bus_err;
`ifdef SRAM_STATS_EN
  logic [7:0]    wr_count;
  logic [7:0]    rd_count;

  modport master (output addr, wr_enable, rd_enable,
                  input  phase, bus_err, wr_count, rd_count);
  modport slave  (input  addr, wr_enable, rd_enable,
                  output phase, bus_err, wr_count, rd_count);
`else
  modport master (output addr, wr_enable, rd_enable,
                  input  phase, bus_err);
  modport slave  (input  addr, wr_enable, rd_enable,
                  output phase, bus_err);
`endif
endinterface

// File: rtl/sram_responder.sv
// Device-side responder for the 8-bit tri-state SRAM bus: register-file memory, phase tracking,
// sticky conflict flag, and saturating access counters when SRAM_STATS_EN is defined.
module sram_responder #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst,
  sram_responder_if.slave    bus,
  inout  wire  [DW-1:0]      sram
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR   = 2'b01,
    RD   = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t        cycle_kind;
  state_t        state;
  logic          bus_err_q;
  logic [1:0]    strobes;
  logic [DW-1:0] mem [DEPTH];

  assign strobes = {bus.wr_enable, bus.rd_enable};

  // Both strobes are active-low; 00 means the master asserted both at once.
  always_comb begin
    cycle_kind = IDLE;
    case (strobes)
      2'b01:   cycle_kind = WR;
      2'b10:   cycle_kind = RD;
      2'b00:   cycle_kind = ERR;
      default: cycle_kind = IDLE;
    endcase
  end

  // Drive enable depends only on the live strobes, so reads stay zero-latency even during reset.
  assign sram = (cycle_kind == RD) ? mem[bus.addr] : {DW{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      state     <= IDLE;
      bus_err_q <= 1'b0;
    end else begin
      state <= cycle_kind;
      if (cycle_kind == WR) begin
        mem[bus.addr] <= sram;
      end
      if (cycle_kind == ERR) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign bus.phase   = state;
  assign bus.bus_err = bus_err_q;

`ifdef SRAM_STATS_EN
  logic [7:0] wr_count_q;
  logic [7:0] rd_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      if ((cycle_kind == WR) && (wr_count_q != 8'hFF)) begin
        wr_count_q <= wr_count_q + 8'd1;
      end
      if ((cycle_kind == RD) && (rd_count_q != 8'hFF)) begin
        rd_count_q <= rd_count_q + 8'd1;
      end
    end
  end

  assign bus.wr_count = wr_count_q;
  assign bus.rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: hand-written vector table plus randomized cycles against a memory model.
// Build with SRAM_STATS_EN defined to also exercise the access counters.
module tb_sram_responder;

  logic       clk;
  logic       rst;
  logic       m_drive;
  logic [7:0] m_data;
  wire  [7:0] sram;

  int total;
  int bad;

  sram_responder_if #(.AW(3)) bus ();

  sram_responder #(.AW(3), .DW(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sram (sram)
  );

  assign sram = m_drive ? m_data : 8'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] strobes;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp_sram;
    logic [1:0] exp_phase;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model: plain memory array and counters driven by the bus rules.
  logic [7:0] ref_mem [8];
  logic [1:0] ref_phase;
  logic       ref_err;
  int         ref_wr;
  int         ref_rd;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive just after an edge, sample sram mid-cycle, then check registered outputs.
  task automatic applyStimulus(input logic r, input logic [1:0] s, input logic [2:0] a,
                               input logic [7:0] d, output logic [7:0] seen_sram,
                               output logic [1:0] seen_phase, output logic seen_err);
    logic is_write, is_read, is_conf;
    is_write = (s == 2'b01);
    is_read  = (s == 2'b10);
    is_conf  = (s == 2'b00);
    rst           = r;
    bus.wr_enable = s[1];
    bus.rd_enable = s[0];
    bus.addr      = a;
    m_drive       = !is_read;
    m_data        = d;
    #4;
    seen_sram = sram;
    checkOutput("sram", seen_sram, is_read ? ref_mem[a] : d);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
      ref_err   = 1'b0;
      ref_wr    = 0;
      ref_rd    = 0;
      ref_phase = 2'd0;
    end else begin
      if (is_write) ref_mem[a] = d;
      if (is_conf) ref_err = 1'b1;
      if (is_write && ref_wr < 255) ref_wr++;
      if (is_read && ref_rd < 255) ref_rd++;
      ref_phase = is_conf ? 2'd3 : is_read ? 2'd2 : is_write ? 2'd1 : 2'd0;
    end
    #1;
    seen_phase = bus.phase;
    seen_err   = bus.bus_err;
    checkOutput("phase", {6'd0, seen_phase}, {6'd0, ref_phase});
    checkOutput("bus_err", {7'd0, seen_err}, {7'd0, ref_err});
`ifdef SRAM_STATS_EN
    checkOutput("wr_count", bus.wr_count, ref_wr[7:0]);
    checkOutput("rd_count", bus.rd_count, ref_rd[7:0]);
`endif
  endtask

  initial begin
    logic [7:0] s_sram;
    logic [1:0] s_phase;
    logic       s_err;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    ref_phase = 2'd0;
    ref_err   = 1'b0;
    ref_wr    = 0;
    ref_rd    = 0;
    m_drive   = 1'b0;
    m_data    = 8'h00;

    // {rst, strobes, addr, data, exp_sram, exp_phase, exp_err}
    vecs.push_back('{1'b1, 2'b11, 3'd0, 8'h00, 8'h00, 2'b00, 1'b0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b0, 2'b10, 3'(i), 8'h00, 8'h00, 2'b10, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'd6, 8'hA5, 8'hA5, 2'b01, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 3'd6, 8'h00, 8'hA5, 2'b10, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 3'd2, 8'h3C, 8'h3C, 2'b11, 1'b1});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 2'b11, 3'd6, 8'h00, 8'h00, 2'b00, 1'b1});
    vecs.push_back('{1'b0, 2'b10, 3'd2, 8'h00, 8'h00, 2'b10, 1'b1});
    vecs.push_back('{1'b1, 2'b01, 3'd1, 8'hFF, 8'hFF, 2'b00, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 3'd1, 8'h00, 8'h00, 2'b10, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 3'd2, 8'h77, 8'h77, 2'b01, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 3'd2, 8'h3C, 8'h3C, 2'b11, 1'b1});
    vecs.push_back('{1'b0, 2'b10, 3'd2, 8'h00, 8'h77, 2'b10, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 3'd2, 8'h00, 8'h77, 2'b00, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 3'd2, 8'h00, 8'h00, 2'b00, 1'b0});
    vecs.push_back('{1'b0, 2'b11, 3'd0, 8'h00, 8'h00, 2'b00, 1'b0});

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].strobes, vecs[i].addr, vecs[i].data,
                    s_sram, s_phase, s_err);
      checkOutput($sformatf("vec%0d_sram", i), s_sram, vecs[i].exp_sram);
      checkOutput($sformatf("vec%0d_phase", i), {6'd0, s_phase}, {6'd0, vecs[i].exp_phase});
      checkOutput($sformatf("vec%0d_err", i), {7'd0, s_err}, {7'd0, vecs[i].exp_err});
    end

    $display("[TB] randomized cycles");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 8'($urandom), s_sram, s_phase, s_err);
    end

`ifdef SRAM_STATS_EN
    $display("[TB] counter saturation");
    applyStimulus(1'b1, 2'b11, 3'd0, 8'h00, s_sram, s_phase, s_err);
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, 2'b01, 3'(i), 8'(i), s_sram, s_phase, s_err);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 2'b10, 3'(i), 8'h00, s_sram, s_phase, s_err);
    checkOutput("wr_count_sat", bus.wr_count, 8'd255);
    checkOutput("rd_count_three", bus.rd_count, 8'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
